// File: rtl/fetch_seq_pkg.sv
// Shared encodings and defaults for the instruction fetch sequencer.
package fetch_seq_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_L = 2'd1,
    FETCH_H = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^ADDR_W.
module program_counter
  import fetch_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte instruction fetch sequencer (low byte, then high byte) with decode handshake.
// Optional per-byte mem_ack timeout enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              branch_load,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ir_e,
  output logic              ir_lh,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic              busy,
  output logic              fetch_err
);

  state_t            state;
  logic              in_fetch;
  logic              timeout;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_load_val;

  assign in_fetch = (state == FETCH_L) || (state == FETCH_H);
  assign pc_inc   = in_fetch && mem_ack;
  assign pc_load  = ((state == IDLE) && branch_load) || timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] saved_pc;
  logic              fetch_start;
  logic              err_q;

  // Low-byte address of the instruction being fetched, restored on timeout.
  assign fetch_start = ((state == IDLE) && !branch_load && start) ||
                       ((state == HOLD) && instr_ack && start);
  assign timeout     = in_fetch && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign pc_load_val = timeout ? saved_pc : branch_addr;
  assign fetch_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      saved_pc <= RESET_PC;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout;
      if (!in_fetch || mem_ack) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (fetch_start) begin
        saved_pc <= pc;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign pc_load_val    = branch_addr;
  assign fetch_err      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Sequencing: branch wins over start in IDLE; ack+start in HOLD skips IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!branch_load && start) state <= FETCH_L;
        end
        FETCH_L: begin
          if (timeout)      state <= IDLE;
          else if (mem_ack) state <= FETCH_H;
        end
        FETCH_H: begin
          if (timeout)      state <= IDLE;
          else if (mem_ack) state <= HOLD;
        end
        HOLD: begin
          if (instr_ack) state <= start ? FETCH_L : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ir_e follows mem_ack so the instruction register captures on the ack edge.
  assign mem_req     = in_fetch;
  assign mem_addr    = pc;
  assign ir_e        = in_fetch && mem_ack;
  assign ir_lh       = (state == FETCH_H) ? LH_HIGH : LH_LOW;
  assign instr_valid = (state == HOLD);
  assign busy        = (state != IDLE);

endmodule
